wb_trace_buffer: RTL and testbench

//   Response side of the Pipeline bench: captures every register-file writeback the MIPS

---
 rtl/wb_trace_pkg.sv | 24 ++
 rtl/wb_trace_fifo.sv | 69 ++++++
 rtl/wb_trace_buffer.sv | 137 +++++++++++++
 tb/tb_wb_trace_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Purpose : shared types for the writeback trace buffer (FSM state, trace entry, widths).
// Latency : n/a (types only).
// Backpressure: n/a. Optional macro TRACE_TIMESTAMP_EN adds a 32-bit cycle field to each entry.
package wb_trace_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } trace_state_e;

    // 69 bits without timestamp, 101 bits with it.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  reg_idx;
        logic [31:0] data;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0] cycle;
`endif
    } trace_entry_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Purpose : parametric show-ahead synchronous FIFO with level/full/empty and sync flush.
// Latency : an entry pushed at edge N is on pop_dat with empty=0 after edge N.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
//   Ports: push/push_dat write side, pop/pop_dat read side (pop_dat = head entry),
//   clr flushes both pointers, full/empty/level report occupancy.
module wb_trace_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_MSB = {1'b1, {AW{1'b0}}};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = ((wr_ptr_q ^ rd_ptr_q) == PTR_MSB);
        level = wr_ptr_q - rd_ptr_q;
        rd_en = pop && !empty && !clr;
        // When full, a simultaneous pop frees the head slot, which is the one written.
        wr_en = push && (!full || rd_en) && !clr;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: contents are only visible through a valid head pointer.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Purpose : captures every register-file writeback retired by the pipeline into a trace FIFO,
//           drained through a valid/ready read port; observes WB only, never stalls it.
// Latency : writeback at edge N visible on rd_* with rd_valid=1 after edge N; backpressure:
//           rd_ready low holds the head; a full FIFO drops (STOP_ON_FULL=0) or halts (=1).
//   Ports: start/clr control, wb_* writeback tap, rd_* read port, level/overflow/drop_cnt/running
//   status. Macro TRACE_TIMESTAMP_EN adds a free-running cycle stamp and the rd_cycle port.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   clr,
    input  logic                   wb_valid,
    input  logic                   wb_we,
    input  logic [31:0]            wb_pc,
    input  logic [4:0]             wb_reg,
    input  logic [31:0]            wb_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [31:0]            rd_pc,
    output logic [4:0]             rd_reg,
    output logic [31:0]            rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [15:0]            drop_cnt,
    output logic                   running
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]            rd_cycle
`endif
);

    trace_state_e          state_q, state_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  store;
    trace_entry_t          wr_entry;
    trace_entry_t          rd_entry;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]           cycle_q, cycle_d;
`endif

    always_comb begin
        // clr dominates every other action in the same cycle.
        push  = (state_q == RUN) && wb_valid && wb_we && !clr;
        pop   = !fifo_empty && rd_ready && !clr;
        drop  = push && fifo_full && !pop;
        store = push && !drop;

        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if ((STOP_ON_FULL != 0) && drop) state_d = HALT;
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {DROP_CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
        end

        wr_entry         = '0;
        wr_entry.pc      = wb_pc;
        wr_entry.reg_idx = wb_reg;
        wr_entry.data    = wb_data;
`ifdef TRACE_TIMESTAMP_EN
        wr_entry.cycle   = cycle_q;
        cycle_d          = clr ? 32'd0 : cycle_q + 32'd1;
`endif
    end

    wb_trace_fifo #(
        .WIDTH ($bits(trace_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .push     (store),
        .push_dat (wr_entry),
        .pop      (pop),
        .pop_dat  (rd_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
`ifdef TRACE_TIMESTAMP_EN
            cycle_q    <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef TRACE_TIMESTAMP_EN
            cycle_q    <= cycle_d;
`endif
        end
    end

    assign rd_valid = !fifo_empty;
    assign rd_pc    = rd_entry.pc;
    assign rd_reg   = rd_entry.reg_idx;
    assign rd_data  = rd_entry.data;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign running  = (state_q == RUN);
`ifdef TRACE_TIMESTAMP_EN
    assign rd_cycle = rd_entry.cycle;
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, clr, wb_valid, wb_we, rd_ready;
    logic [31:0] wb_pc, wb_data;
    logic [4:0]  wb_reg;

    // dut: drop on full; dut_h: halt on full. Both share stimulus.
    logic        rd_valid, overflow, running;
    logic [31:0] rd_pc, rd_data;
    logic [4:0]  rd_reg, level;
    logic [15:0] drop_cnt;
    logic        rd_valid_h, overflow_h, running_h;
    logic [31:0] rd_pc_h, rd_data_h;
    logic [4:0]  rd_reg_h, level_h;
    logic [15:0] drop_cnt_h;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] rd_cycle, rd_cycle_h;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(16), .STOP_ON_FULL(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_pc(wb_pc), .wb_reg(wb_reg), .wb_data(wb_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_reg(rd_reg), .rd_data(rd_data),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .running(running)
`ifdef TRACE_TIMESTAMP_EN
        , .rd_cycle(rd_cycle)
`endif
    );

    wb_trace_buffer #(.DEPTH(16), .STOP_ON_FULL(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_pc(wb_pc), .wb_reg(wb_reg), .wb_data(wb_data),
        .rd_valid(rd_valid_h), .rd_ready(rd_ready), .rd_pc(rd_pc_h), .rd_reg(rd_reg_h),
        .rd_data(rd_data_h), .level(level_h), .overflow(overflow_h), .drop_cnt(drop_cnt_h),
        .running(running_h)
`ifdef TRACE_TIMESTAMP_EN
        , .rd_cycle(rd_cycle_h)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_drive(input logic v, input logic [31:0] pc, input logic [4:0] r, input logic [31:0] d);
        wb_valid = v;
        wb_we    = v;
        wb_pc    = pc;
        wb_reg   = r;
        wb_data  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; clr = 0; rd_ready = 0;
        wb_drive(1'b0, 32'd0, 5'd0, 32'd0);
        tick(); tick();
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        n_tests++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
        n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b exp 0", running); end
        rst_n = 1'b1;
        tick();
        n_tests++; if (running !== 1'b0 || running_h !== 1'b0) begin n_fail++; $display("FAIL idle_no_start got %b/%b exp 0/0", running, running_h); end
    endtask

    task automatic test_basic();
        start = 1; tick(); start = 0;
        n_tests++; if (running !== 1'b1 || running_h !== 1'b1) begin n_fail++; $display("FAIL start_running got %b/%b exp 1/1", running, running_h); end
        rd_ready = 1;
        for (int i = 0; i < 3; i++) begin
            wb_drive(1'b1, 32'(i * 4), 5'(i + 1), 32'(5 + i));
            tick();
            n_tests++;
            if (rd_valid !== 1'b1 || rd_pc !== 32'(i * 4) || rd_reg !== 5'(i + 1) || rd_data !== 32'(5 + i) || level !== 5'd1) begin
                n_fail++;
                $display("FAIL basic_entry%0d got v=%b pc=%h reg=%0d data=%0d lvl=%0d exp v=1 pc=%h reg=%0d data=%0d lvl=1",
                         i, rd_valid, rd_pc, rd_reg, rd_data, level, i * 4, i + 1, 5 + i);
            end
        end
        wb_drive(1'b0, 32'd0, 5'd0, 32'd0);
        tick();
        n_tests++; if (level !== 5'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got lvl=%0d v=%b exp 0/0", level, rd_valid); end
    endtask

    task automatic test_no_we();
        wb_valid = 1; wb_we = 0; wb_pc = 32'h40; wb_reg = 5'd9; wb_data = 32'h99;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (level !== 5'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL no_we_cyc%0d got lvl=%0d v=%b exp 0/0", i, level, rd_valid); end
        end
        wb_valid = 0;
    endtask

    task automatic test_overflow();
        rd_ready = 0;
        for (int i = 0; i < 18; i++) begin
            wb_drive(1'b1, 32'(i * 4), 5'(i), 32'h100 + 32'(i));
            tick();
            if (i == 15) begin
                n_tests++; if (level !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at16 got lvl=%0d ovf=%b exp 16/0", level, overflow); end
            end
        end
        wb_drive(1'b0, 32'd0, 5'd0, 32'd0);
        n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level got %0d exp 16", level); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        n_tests++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_cnt got %0d exp 2", drop_cnt); end
        n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL ovf_running got %b exp 1", running); end
        n_tests++; if (rd_valid !== 1'b1 || rd_pc !== 32'h0 || rd_data !== 32'h100) begin n_fail++; $display("FAIL ovf_head got v=%b pc=%h d=%h exp 1/0/100", rd_valid, rd_pc, rd_data); end
        n_tests++; if (level_h !== 5'd16 || running_h !== 1'b0) begin n_fail++; $display("FAIL halt_state got lvl=%0d run=%b exp 16/0", level_h, running_h); end
        n_tests++; if (drop_cnt_h !== 16'd1 || overflow_h !== 1'b1) begin n_fail++; $display("FAIL halt_drop got cnt=%0d ovf=%b exp 1/1", drop_cnt_h, overflow_h); end
    endtask

    task automatic test_full_push_pop();
        int idx;
        rd_ready = 1;
        wb_drive(1'b1, 32'h48, 5'd18, 32'h112);
        tick();
        wb_drive(1'b0, 32'd0, 5'd0, 32'd0);
        n_tests++; if (level !== 5'd16 || drop_cnt !== 16'd2) begin n_fail++; $display("FAIL fullpp_level got lvl=%0d cnt=%0d exp 16/2", level, drop_cnt); end
        for (int k = 0; k < 16; k++) begin
            idx = (k < 15) ? k + 1 : 18;
            n_tests++;
            if (rd_valid !== 1'b1 || rd_pc !== 32'(idx * 4) || rd_reg !== 5'(idx) || rd_data !== 32'h100 + 32'(idx)) begin
                n_fail++;
                $display("FAIL drain%0d got v=%b pc=%h reg=%0d data=%h exp v=1 pc=%h reg=%0d data=%h",
                         k, rd_valid, rd_pc, rd_reg, rd_data, idx * 4, idx, 32'h100 + 32'(idx));
            end
            tick();
        end
        n_tests++; if (level !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL drain_end got lvl=%0d v=%b ovf=%b exp 0/0/1", level, rd_valid, overflow); end
    endtask

    task automatic test_halt_clr();
        rd_ready = 0;
        wb_drive(1'b1, 32'h80, 5'd7, 32'h77);
        tick();
        n_tests++; if (level_h !== 5'd0 || drop_cnt_h !== 16'd1 || level !== 5'd1) begin n_fail++; $display("FAIL halt_ignore got lvl_h=%0d cnt_h=%0d lvl=%0d exp 0/1/1", level_h, drop_cnt_h, level); end
        clr = 1; start = 1;
        tick();
        clr = 0; start = 0;
        wb_drive(1'b0, 32'd0, 5'd0, 32'd0);
        n_tests++; if (running !== 1'b0 || running_h !== 1'b0) begin n_fail++; $display("FAIL clr_idle got %b/%b exp 0/0", running, running_h); end
        n_tests++; if (level !== 5'd0 || level_h !== 5'd0) begin n_fail++; $display("FAIL clr_level got %0d/%0d exp 0/0", level, level_h); end
        n_tests++; if (overflow !== 1'b0 || drop_cnt !== 16'd0 || drop_cnt_h !== 16'd0) begin n_fail++; $display("FAIL clr_flags got ovf=%b cnt=%0d cnt_h=%0d exp 0/0/0", overflow, drop_cnt, drop_cnt_h); end
        start = 1; tick(); start = 0;
        n_tests++; if (running_h !== 1'b1) begin n_fail++; $display("FAIL halt_restart got %b exp 1", running_h); end
        wb_drive(1'b1, 32'hC0, 5'd3, 32'h33);
        tick();
        wb_drive(1'b0, 32'd0, 5'd0, 32'd0);
        n_tests++; if (level_h !== 5'd1 || rd_pc_h !== 32'hC0) begin n_fail++; $display("FAIL restart_push got lvl=%0d pc=%h exp 1/c0", level_h, rd_pc_h); end
        clr = 1; tick(); clr = 0;
    endtask

`ifdef TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        rd_ready = 0;
        clr = 1; tick(); clr = 0;
        start = 1; tick(); start = 0;
        tick(); tick();
        wb_drive(1'b1, 32'h100, 5'd1, 32'h1); tick();
        wb_drive(1'b0, 32'd0, 5'd0, 32'd0);
        tick(); tick(); tick();
        wb_drive(1'b1, 32'h104, 5'd2, 32'h2); tick();
        wb_drive(1'b0, 32'd0, 5'd0, 32'd0);
        n_tests++; if (level !== 5'd2 || rd_cycle !== 32'd3) begin n_fail++; $display("FAIL ts_first got lvl=%0d cyc=%0d exp 2/3", level, rd_cycle); end
        rd_ready = 1; tick(); rd_ready = 0;
        n_tests++; if (rd_cycle !== 32'd7 || rd_pc !== 32'h104) begin n_fail++; $display("FAIL ts_second got cyc=%0d pc=%h exp 7/104", rd_cycle, rd_pc); end
        clr = 1; tick(); clr = 0;
    endtask
`endif

    task automatic test_reset_mid();
        rd_ready = 0;
        start = 1; tick(); start = 0;
        wb_drive(1'b1, 32'h200, 5'd4, 32'h44); tick();
        wb_drive(1'b1, 32'h204, 5'd5, 32'h55); tick();
        n_tests++; if (level !== 5'd2 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst got lvl=%0d v=%b exp 2/1", level, rd_valid); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (rd_valid !== 1'b0 || level !== 5'd0 || running !== 1'b0) begin n_fail++; $display("FAIL rst_mid got v=%b lvl=%0d run=%b exp 0/0/0", rd_valid, level, running); end
        wb_drive(1'b0, 32'd0, 5'd0, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++; if (rd_valid !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL post_rst got v=%b run=%b exp 0/0", rd_valid, running); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_we();
        test_overflow();
        test_full_push_pop();
        test_halt_clr();
`ifdef TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
